// File: rtl/ctrl_sequencer_if.sv
// Opcode-in / control-word-out bundle for ctrl_sequencer.
// master: instruction fetch side; slave: the sequencer.
interface ctrl_sequencer_if #(
  parameter int unsigned OPW   = 3,
  parameter int unsigned CNT_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [OPW-1:0]   opcode;
  logic             resume;
  logic             ctl_valid;
  logic             bez;
  logic             ja;
  logic             op1;
  logic [1:0]       op2;
  logic             writeReg;
  logic             writex8;
  logic [1:0]       x8Sel;
  logic             mem_busy;
  logic             halted;
  logic             illegal;
  logic [CNT_W-1:0] retired;

  modport master (
    output in_valid, opcode, resume,
    input  in_ready, ctl_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel,
           mem_busy, halted, illegal, retired
  );

  modport slave (
    input  in_valid, opcode, resume,
    output in_ready, ctl_valid, bez, ja, op1, op2, writeReg, writex8, x8Sel,
           mem_busy, halted, illegal, retired
  );
endinterface

// File: rtl/ctrl_sequencer.sv
// Registered, handshaked opcode sequencer: one control word per accepted opcode,
// lr/sr delayed by MEM_WAIT cycles, with halt/resume, illegal flag and retire count.
module ctrl_sequencer #(
  parameter int unsigned OPW      = 3,
  parameter int unsigned MEM_WAIT = 2,
  parameter int unsigned CNT_W    = 8
) (
  input logic             clk,
  input logic             rst,
  ctrl_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HALT} state_t;

  typedef struct packed {
    logic       bez;
    logic       ja;
    logic       op1;
    logic [1:0] op2;
    logic       write_reg;
    logic       writex8;
    logic [1:0] x8sel;
  } cw_t;

  state_t           state_q, state_d;
  cw_t              cw_q, cw_d;
  logic [3:0]       wcnt_q, wcnt_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] retired_q;
  logic [2:0]       op_lo;
  logic             accept, legal, is_mem, is_hlt;

  function automatic cw_t decode(input logic [2:0] op);
    cw_t w;
    w = '0;
    case (op)
      3'b000: begin w.bez = 1'b1; w.op2 = 2'd1; end
      3'b001: begin w.writex8 = 1'b1; w.x8sel = 2'd1; end
      3'b010: begin w.ja = 1'b1; w.op1 = 1'b1; w.op2 = 2'd1; end
      3'b011: begin w.writex8 = 1'b1; w.x8sel = 2'd1; end
      3'b100: begin w.writex8 = 1'b1; end
      3'b101: begin w.op1 = 1'b1; w.writex8 = 1'b1; w.x8sel = 2'd2; end
      3'b110: begin w.write_reg = 1'b1; end
      default: w = '0;
    endcase
    return w;
  endfunction

  assign op_lo  = bus.opcode[2:0];
  assign legal  = (bus.opcode >> 3) == '0;
  assign is_mem = (op_lo == 3'b100) || (op_lo == 3'b110);
  assign is_hlt = (op_lo == 3'b111);
  assign accept = bus.in_valid & bus.in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // retired counts on entry to ISSUE so the count already includes the live word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cw_q      <= '0;
      wcnt_q    <= '0;
      illegal_q <= 1'b0;
      retired_q <= '0;
    end else begin
      cw_q      <= cw_d;
      wcnt_q    <= wcnt_d;
      illegal_q <= illegal_d;
      if (state_d == ISSUE) retired_q <= retired_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    cw_d      = cw_q;
    wcnt_d    = wcnt_q;
    illegal_d = 1'b0;
    case (state_q)
      IDLE, ISSUE: begin
        state_d = IDLE;
        if (accept) begin
          cw_d   = '0;
          wcnt_d = '0;
          if (!legal) begin
            illegal_d = 1'b1;
          end else if (is_hlt) begin
            state_d = HALT;
          end else begin
            cw_d = decode(op_lo);
            if (is_mem && (MEM_WAIT != 0)) begin
              state_d = WAIT;
              wcnt_d  = 4'(MEM_WAIT);
            end else begin
              state_d = ISSUE;
            end
          end
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) state_d = ISSUE;
      end
      HALT: begin
        if (bus.resume) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE) || (state_q == ISSUE);
    bus.ctl_valid = (state_q == ISSUE);
    bus.mem_busy  = (state_q == WAIT);
    bus.halted    = (state_q == HALT);
    bus.illegal   = illegal_q;
    bus.retired   = retired_q;
    bus.bez       = 1'b0;
    bus.ja        = 1'b0;
    bus.op1       = 1'b0;
    bus.op2       = '0;
    bus.writeReg  = 1'b0;
    bus.writex8   = 1'b0;
    bus.x8Sel     = '0;
    // select fields stay visible through WAIT; write enables only in ISSUE
    if ((state_q == ISSUE) || (state_q == WAIT)) begin
      bus.bez = cw_q.bez;
      bus.ja  = cw_q.ja;
      bus.op1 = cw_q.op1;
      bus.op2 = cw_q.op2;
    end
    if (state_q == ISSUE) begin
      bus.writeReg = cw_q.write_reg;
      bus.writex8  = cw_q.writex8;
      bus.x8Sel    = cw_q.x8sel;
    end
  end

endmodule

// File: tb/tb_ctrl_sequencer.sv
// Self-checking bench for ctrl_sequencer: a table of opcodes with expected control
// words feeds a scoreboard, plus hand sequences for wait, halt, illegal, reset and wrap.
module tb_ctrl_sequencer;

  typedef struct {
    logic [3:0] op;
    logic [8:0] cw;   // {bez,ja,op1,op2,writeReg,writex8,x8Sel}
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [8:0] sbq[$];
  logic [8:0] mon_exp;
  logic [8:0] wrd_a;
  vec_t vecs[8];

  ctrl_sequencer_if #(.OPW(4), .CNT_W(8)) a ();
  ctrl_sequencer_if #(.OPW(3), .CNT_W(8)) b ();

  ctrl_sequencer #(.OPW(4), .MEM_WAIT(2), .CNT_W(8)) u_a (
    .clk (clk),
    .rst (rst),
    .bus (a.slave)
  );

  ctrl_sequencer #(.OPW(3), .MEM_WAIT(0), .CNT_W(8)) u_b (
    .clk (clk),
    .rst (rst),
    .bus (b.slave)
  );

  assign wrd_a = {a.bez, a.ja, a.op1, a.op2, a.writeReg, a.writex8, a.x8Sel};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold the opcode until the sequencer accepts it, bounded.
  task automatic send(input logic [3:0] op, input logic [8:0] cw, input bit expect_issue);
    bit done;
    done = 1'b0;
    a.in_valid = 1'b1;
    a.opcode   = op;
    for (int unsigned k = 0; k < 20 && !done; k++) begin
      if (a.in_ready) begin
        if (expect_issue) sbq.push_back(cw);
        done = 1'b1;
      end
      step();
    end
    a.in_valid = 1'b0;
    if (!done) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Every issued word must match the oldest expected word; writes only with ctl_valid.
  always @(negedge clk) begin
    if (a.ctl_valid) begin
      checks++;
      if (sbq.size() == 0) begin
        errors++;
        $display("FAIL issue_unexpected act=%b exp=none", wrd_a);
      end else begin
        mon_exp = sbq.pop_front();
        if (wrd_a !== mon_exp) begin
          errors++;
          $display("FAIL issue_word act=%b exp=%b", wrd_a, mon_exp);
        end
      end
    end else if (a.writeReg || a.writex8) begin
      checks++;
      errors++;
      $display("FAIL write_outside_issue act=%b exp=no_write", wrd_a);
    end
  end

  initial begin
    bit seen;
    checks = 0;
    errors = 0;
    vecs[0] = '{4'b0001, 9'b0_0_0_00_0_1_01};  // li
    vecs[1] = '{4'b0011, 9'b0_0_0_00_0_1_01};  // add
    vecs[2] = '{4'b0101, 9'b0_0_1_00_0_1_10};  // not
    vecs[3] = '{4'b0000, 9'b1_0_0_01_0_0_00};  // bez
    vecs[4] = '{4'b0010, 9'b0_1_1_01_0_0_00};  // ja
    vecs[5] = '{4'b0100, 9'b0_0_0_00_0_1_00};  // lr
    vecs[6] = '{4'b0110, 9'b0_0_0_00_1_0_00};  // sr
    vecs[7] = '{4'b0011, 9'b0_0_0_00_0_1_01};  // add

    rst = 1'b1;
    a.in_valid = 1'b0; a.opcode = '0; a.resume = 1'b0;
    b.in_valid = 1'b0; b.opcode = '0; b.resume = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_in_ready",  32'(a.in_ready), 32'd1);
    chk("rst_ctl_valid", 32'(a.ctl_valid), 32'd0);
    chk("rst_retired",   32'(a.retired), 32'd0);
    chk("rst_halted",    32'(a.halted), 32'd0);
    chk("rst_mem_busy",  32'(a.mem_busy), 32'd0);

    // li accepted at the next edge, issued the cycle after
    a.in_valid = 1'b1; a.opcode = 4'b0001; sbq.push_back(vecs[0].cw);
    step();
    a.in_valid = 1'b0;
    chk("li_ctl_valid", 32'(a.ctl_valid), 32'd1);
    chk("li_writex8",   32'(a.writex8), 32'd1);
    chk("li_x8sel",     32'(a.x8Sel), 32'd1);
    chk("li_retired",   32'(a.retired), 32'd1);
    step();
    chk("li_idle", 32'(a.ctl_valid), 32'd0);

    // back-to-back add, not, bez
    for (int i = 1; i <= 3; i++) begin
      a.in_valid = 1'b1; a.opcode = vecs[i].op; sbq.push_back(vecs[i].cw);
      step();
      chk("b2b_ctl_valid", 32'(a.ctl_valid), 32'd1);
      chk("b2b_in_ready",  32'(a.in_ready), 32'd1);
    end
    a.in_valid = 1'b0;
    chk("b2b_retired", 32'(a.retired), 32'd4);
    step();

    // lr with two wait cycles
    a.in_valid = 1'b1; a.opcode = 4'b0100; sbq.push_back(vecs[5].cw);
    step();
    a.in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("lr_mem_busy",  32'(a.mem_busy), 32'd1);
      chk("lr_in_ready",  32'(a.in_ready), 32'd0);
      chk("lr_wait_wx8",  32'(a.writex8), 32'd0);
      chk("lr_wait_ctl",  32'(a.ctl_valid), 32'd0);
      step();
    end
    chk("lr_issue_ctl", 32'(a.ctl_valid), 32'd1);
    chk("lr_issue_wx8", 32'(a.writex8), 32'd1);
    chk("lr_issue_sel", 32'(a.x8Sel), 32'd0);
    chk("lr_issue_busy", 32'(a.mem_busy), 32'd0);
    chk("lr_retired",   32'(a.retired), 32'd5);
    step();

    // lr without wait cycles on the second instance
    b.in_valid = 1'b1; b.opcode = 3'b100;
    step();
    b.in_valid = 1'b0;
    chk("lr0_ctl_valid", 32'(b.ctl_valid), 32'd1);
    chk("lr0_writex8",   32'(b.writex8), 32'd1);
    chk("lr0_mem_busy",  32'(b.mem_busy), 32'd0);
    chk("lr0_retired",   32'(b.retired), 32'd1);
    step();
    chk("lr0_done", 32'(b.ctl_valid), 32'd0);

    // HLT, ignored in_valid pulses, resume, then sr
    a.in_valid = 1'b1; a.opcode = 4'b0111;
    step();
    a.in_valid = 1'b0;
    chk("hlt_halted", 32'(a.halted), 32'd1);
    chk("hlt_ready",  32'(a.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      a.in_valid = 1'b1; a.opcode = 4'b0011;
      step();
      a.in_valid = 1'b0;
      step();
      chk("hlt_hold", 32'(a.halted), 32'd1);
    end
    a.resume = 1'b1;
    step();
    a.resume = 1'b0;
    chk("resume_halted", 32'(a.halted), 32'd0);
    chk("resume_ready",  32'(a.in_ready), 32'd1);
    a.in_valid = 1'b1; a.opcode = 4'b0110; sbq.push_back(vecs[6].cw);
    step();
    a.in_valid = 1'b0;
    chk("sr_busy", 32'(a.mem_busy), 32'd1);
    step(); step();
    chk("sr_ctl",      32'(a.ctl_valid), 32'd1);
    chk("sr_writereg", 32'(a.writeReg), 32'd1);
    chk("sr_retired",  32'(a.retired), 32'd6);
    step();

    // illegal opcode with high bit set
    a.in_valid = 1'b1; a.opcode = 4'b1011;
    step();
    a.in_valid = 1'b0;
    chk("ill_pulse",   32'(a.illegal), 32'd1);
    chk("ill_ctl",     32'(a.ctl_valid), 32'd0);
    chk("ill_retired", 32'(a.retired), 32'd6);
    chk("ill_ready",   32'(a.in_ready), 32'd1);
    step();
    chk("ill_clear", 32'(a.illegal), 32'd0);

    // table-driven stream through the scoreboard
    foreach (vecs[i]) send(vecs[i].op, vecs[i].cw, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("table_retired", 32'(a.retired), 32'd14);
    chk("table_drained", 32'(sbq.size()), 32'd0);

    // reset during the wait of an sr drops it
    a.in_valid = 1'b1; a.opcode = 4'b0110;
    step();
    a.in_valid = 1'b0;
    chk("rstw_busy", 32'(a.mem_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("rstw_busy0",   32'(a.mem_busy), 32'd0);
    chk("rstw_ctl",     32'(a.ctl_valid), 32'd0);
    chk("rstw_wr",      32'(a.writeReg), 32'd0);
    chk("rstw_retired", 32'(a.retired), 32'd0);
    chk("rstw_ready",   32'(a.in_ready), 32'd1);
    step();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (a.writeReg || a.ctl_valid) seen = 1'b1;
    end
    chk("rstw_dropped", 32'(seen), 32'd0);

    // 256 issues wrap the 8-bit retire counter
    for (int i = 0; i < 256; i++) begin
      a.in_valid = 1'b1; a.opcode = 4'b0011; sbq.push_back(vecs[1].cw);
      step();
      if (i == 254) chk("wrap_255", 32'(a.retired), 32'd255);
    end
    a.in_valid = 1'b0;
    chk("wrap_zero", 32'(a.retired), 32'd0);
    step(); step();
    chk("final_drained", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
